// File: rtl/ir_multibyte_pkg.sv
// Shared constants for the multi-byte instruction register, the control-ROM generator and the bench.
// Holds default geometry, the strobe decode type and the counter-width derivation.
package ir_multibyte_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int OPERANDS_DEF = 2;

  // Strobe combination seen at a clock edge: {advance, load}, both already active-high.
  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_LOAD    = 2'b01,
    OP_ADVANCE = 2'b10,
    OP_BOTH    = 2'b11
  } op_e;

  function automatic int cw_of(input int operands);
    return $clog2(operands + 2);
  endfunction

  // Operand bus is zero words wide when OPERANDS=0; keep one tied-off bit so the port exists.
  function automatic int opw_of(input int width, input int operands);
    return (operands > 0) ? width * operands : 1;
  endfunction

endpackage

// File: rtl/ir_multibyte_if.sv
// Bus-side strobes and decoder-side outputs of the multi-byte instruction register.
// The bus master drives loads/advances; the register (slave) returns the instruction.
interface ir_multibyte_if
  import ir_multibyte_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int OPERANDS = OPERANDS_DEF
);
  localparam int CW  = cw_of(OPERANDS);
  localparam int OPW = opw_of(WIDTH, OPERANDS);

  logic             loadn;
  logic             advancen;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] instr_out;
  logic [OPW-1:0]   operand_out;
  logic [CW-1:0]    count_out;
  logic [CW-1:0]    staged_count;
  logic             full;
  logic             overflow;

  modport master (
    output loadn, advancen, bus,
    input  instr_out, operand_out, count_out, staged_count, full, overflow
  );

  modport slave (
    input  loadn, advancen, bus,
    output instr_out, operand_out, count_out, staged_count, full, overflow
  );

endinterface

// File: rtl/ir_multibyte_slot.sv
// One instruction word register: async reset, load enable and synchronous clear.
// Load wins over clear so a staging slot can restart with the bus word on a combined strobe.
module ir_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_clear) begin
      r_q <= '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ir_multibyte.sv
// Two-rank multi-byte instruction register: words fill a staging rank one per load,
// an advance moves the whole staged instruction to the output rank seen by the decoder.
module ir_multibyte
  import ir_multibyte_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int OPERANDS = OPERANDS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  ir_multibyte_if.slave bif
);

  localparam int CW = cw_of(OPERANDS);
  localparam int NS = OPERANDS + 1;

  op_e              w_op;
  logic             w_full;
  logic [CW-1:0]    r_staged_count;
  logic [CW-1:0]    r_count_out;
  logic             r_overflow;
  logic [WIDTH-1:0] w_stage_q [NS];
  logic [WIDTH-1:0] w_out_q   [NS];

  assign w_op   = op_e'({~bif.advancen, ~bif.loadn});
  assign w_full = (r_staged_count == CW'(NS));

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slot
      logic w_stage_load;
      logic w_adv;

      // A plain load targets the next free slot; a combined strobe restarts the rank at slot 0.
      assign w_stage_load = ((w_op == OP_LOAD) && !w_full && (r_staged_count == CW'(gi))) ||
                            ((w_op == OP_BOTH) && (gi == 0));
      assign w_adv = (w_op == OP_ADVANCE) || (w_op == OP_BOTH);

      ir_slot #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_stage_load),
        .i_clear (w_adv),
        .i_d     (bif.bus),
        .o_q     (w_stage_q[gi])
      );

      // Unfilled staging slots are always zero, so copying them keeps unused outputs at zero.
      ir_slot #(.WIDTH(WIDTH)) u_out (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_adv),
        .i_clear (1'b0),
        .i_d     (w_stage_q[gi]),
        .o_q     (w_out_q[gi])
      );
    end

    if (OPERANDS > 0) begin : g_operands
      for (gi = 1; gi < NS; gi++) begin : g_op
        assign bif.operand_out[(gi-1)*WIDTH +: WIDTH] = w_out_q[gi];
      end
    end else begin : g_no_operands
      assign bif.operand_out = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_staged_count <= '0;
      r_count_out    <= '0;
      r_overflow     <= 1'b0;
    end else begin
      case (w_op)
        OP_LOAD: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_staged_count <= r_staged_count + 1'b1;
          end
        end
        OP_ADVANCE: begin
          r_count_out    <= r_staged_count;
          r_staged_count <= '0;
        end
        OP_BOTH: begin
          r_count_out    <= r_staged_count;
          r_staged_count <= CW'(1);
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && !bif.loadn) begin
      assert (!$isunknown(bif.bus)) else $error("Attempting to load %b", bif.bus);
    end
  end

  assign bif.instr_out    = w_out_q[0];
  assign bif.count_out    = r_count_out;
  assign bif.staged_count = r_staged_count;
  assign bif.full         = w_full;
  assign bif.overflow     = r_overflow;

endmodule

// File: tb/tb_ir_multibyte.sv
// Bench for ir_multibyte: an 8-bit/2-operand and a 16-bit/0-operand instance run side by side
// against a word-list reference model, with directed scenarios followed by random traffic.
module tb_ir_multibyte;

  logic clk;
  logic reset;

  ir_multibyte_if #(.WIDTH(8),  .OPERANDS(2)) bif_a ();
  ir_multibyte_if #(.WIDTH(16), .OPERANDS(0)) bif_b ();

  ir_multibyte #(.WIDTH(8),  .OPERANDS(2)) dut_a (.clk(clk), .reset(reset), .bif(bif_a));
  ir_multibyte #(.WIDTH(16), .OPERANDS(0)) dut_b (.clk(clk), .reset(reset), .bif(bif_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: per config a list of staged words and the instruction held on the output.
  int          cap   [2] = '{3, 1};
  logic [15:0] st    [2][3];
  int          st_n  [2];
  logic [15:0] ow    [2][3];
  int          ow_n  [2];
  bit          ovf   [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        st[c][k] = '0;
        ow[c][k] = '0;
      end
      st_n[c] = 0;
      ow_n[c] = 0;
      ovf[c]  = 0;
    end
  endtask

  task automatic model_edge(input int c, input bit ld, input bit adv, input logic [15:0] w);
    if (adv) begin
      for (int k = 0; k < 3; k++) begin
        ow[c][k] = (k < st_n[c]) ? st[c][k] : 16'h0;
        st[c][k] = '0;
      end
      ow_n[c] = st_n[c];
      st_n[c] = 0;
      if (ld) begin
        st[c][0] = w;
        st_n[c]  = 1;
      end
    end else if (ld) begin
      if (st_n[c] == cap[c]) begin
        ovf[c] = 1;
      end else begin
        st[c][st_n[c]] = w;
        st_n[c]++;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, " a.instr"},    32'(bif_a.instr_out),    32'(ow[0][0][7:0]));
    check({ctx, " a.operand"},  32'(bif_a.operand_out),  32'({ow[0][2][7:0], ow[0][1][7:0]}));
    check({ctx, " a.count"},    32'(bif_a.count_out),    32'(ow_n[0]));
    check({ctx, " a.staged"},   32'(bif_a.staged_count), 32'(st_n[0]));
    check({ctx, " a.full"},     32'(bif_a.full),         32'(st_n[0] == cap[0]));
    check({ctx, " a.overflow"}, 32'(bif_a.overflow),     32'(ovf[0]));
    check({ctx, " b.instr"},    32'(bif_b.instr_out),    32'(ow[1][0]));
    check({ctx, " b.operand"},  32'(bif_b.operand_out),  32'(0));
    check({ctx, " b.count"},    32'(bif_b.count_out),    32'(ow_n[1]));
    check({ctx, " b.staged"},   32'(bif_b.staged_count), 32'(st_n[1]));
    check({ctx, " b.full"},     32'(bif_b.full),         32'(st_n[1] == cap[1]));
    check({ctx, " b.overflow"}, 32'(bif_b.overflow),     32'(ovf[1]));
  endtask

  // One clock edge with the given strobes; word wa goes to the 8-bit unit, wb to the 16-bit one.
  task automatic step(input string ctx, input bit ld, input bit adv,
                      input logic [7:0] wa, input logic [15:0] wb);
    bif_a.loadn    = ~ld;
    bif_a.advancen = ~adv;
    bif_a.bus      = wa;
    bif_b.loadn    = ~ld;
    bif_b.advancen = ~adv;
    bif_b.bus      = wb;
    @(posedge clk);
    #1;
    model_edge(0, ld, adv, {8'h00, wa});
    model_edge(1, ld, adv, wb);
    $display("%s ld=%0b adv=%0b a:bus=%h instr=%h ops=%h cnt=%0d stg=%0d ovf=%0b b:bus=%h instr=%h cnt=%0d stg=%0d ovf=%0b",
             ctx, ld, adv, wa, bif_a.instr_out, bif_a.operand_out, bif_a.count_out,
             bif_a.staged_count, bif_a.overflow, wb, bif_b.instr_out, bif_b.count_out,
             bif_b.staged_count, bif_b.overflow);
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    bif_a.loadn = 1'b1; bif_a.advancen = 1'b1; bif_a.bus = '0;
    bif_b.loadn = 1'b1; bif_b.advancen = 1'b1; bif_b.bus = '0;
  endtask

  // Reset lands between edges and must clear state before the next edge.
  task automatic do_reset(input string ctx);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    $display("%s reset asserted a:stg=%0d cnt=%0d b:stg=%0d cnt=%0d", ctx,
             bif_a.staged_count, bif_a.count_out, bif_b.staged_count, bif_b.count_out);
    check_all(ctx);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;

    // Reset mid-fill
    step("midfill", 1, 0, 8'hA5, 16'hBEEF);
    do_reset("midfill_rst");

    // Three-word instruction
    step("three", 1, 0, 8'h3C, 16'h1234);
    step("three", 1, 0, 8'h11, 16'h5678);
    step("three", 1, 0, 8'h22, 16'h9ABC);
    step("three_adv", 0, 1, 8'h00, 16'h0000);
    check("three literal instr", 32'(bif_a.instr_out), 32'h3C);
    check("three literal ops",   32'(bif_a.operand_out), 32'h2211);
    check("three literal b.ovf", 32'(bif_b.overflow), 32'h1);

    // Short instruction
    step("short", 1, 0, 8'h07, 16'h0707);
    step("short_adv", 0, 1, 8'h00, 16'h0000);
    check("short literal cnt", 32'(bif_a.count_out), 32'd1);

    // Overflow is sticky across advances
    do_reset("ovf_rst");
    for (int i = 0; i < 4; i++) step("ovf", 1, 0, 8'(8'h40 + i), 16'(16'h4000 + i));
    check("ovf literal a.ovf", 32'(bif_a.overflow), 32'h1);
    step("ovf_adv", 0, 1, 8'h00, 16'h0000);
    step("ovf_idle", 0, 0, 8'hFF, 16'hFFFF);

    // Simultaneous load and advance
    do_reset("sim_rst");
    step("sim", 1, 0, 8'h10, 16'h1010);
    step("sim", 1, 0, 8'h20, 16'h2020);
    step("sim_both", 1, 1, 8'h30, 16'h3030);
    check("sim literal ops", 32'(bif_a.operand_out), 32'h0020);
    step("sim_adv", 0, 1, 8'h00, 16'h0000);
    check("sim literal instr", 32'(bif_a.instr_out), 32'h30);

    // Full rank plus combined strobe does not overflow
    do_reset("fullboth_rst");
    for (int i = 0; i < 3; i++) step("fullboth", 1, 0, 8'(8'h50 + i), 16'(16'h5000 + i));
    step("fullboth_both", 1, 1, 8'h5F, 16'h5F5F);

    // Output hold across loads, then empty advance
    do_reset("hold_rst");
    step("hold", 1, 0, 8'h66, 16'h6666);
    step("hold_adv", 0, 1, 8'h00, 16'h0000);
    for (int i = 0; i < 5; i++) step("hold_load", 1, 0, 8'($urandom), 16'($urandom));
    step("hold_adv2", 0, 1, 8'h00, 16'h0000);
    step("empty_adv", 0, 1, 8'h00, 16'h0000);
    check("empty literal cnt", 32'(bif_a.count_out), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 30),
             8'($urandom), 16'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ir_multibyte.md
Name: ir_multibyte

Overview:
- Parametrised successor of the 8-bit two-rank instruction register.
- Assembles a multi-byte instruction (opcode plus up to OPERANDS operand words) from the data bus into a staging rank, one word per load cycle.
- Transfers the staged instruction to an output rank on an advance strobe, on the same single clock.
- Sits between the bus and the control-ROM/microcode decoder. Operand words feed immediate and address paths.

Parameters:
- WIDTH, 8, bus and word width in bits.
- OPERANDS, 2, maximum operand words after the opcode (0 gives a plain pipelined IR).
- CW (localparam), $clog2(OPERANDS+2), width of the word counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- loadn  in  1  active-low; at the clk edge, capture bus into the next free staging slot.
- advancen  in  1  active-low; at the clk edge, copy the staging rank to the output rank and empty the staging rank.
- bus  in  WIDTH  data bus.
- instr_out  out  WIDTH  opcode word (output slot 0).
- operand_out  out  OPERANDS*WIDTH  operand words; operand k is at bits [k*WIDTH +: WIDTH], k=0 is the first operand.
- count_out  out  CW  number of valid words in the output rank (0..OPERANDS+1).
- staged_count  out  CW  number of words currently staged.
- full  out  1  staged_count == OPERANDS+1 (combinational from the counter).
- overflow  out  1  sticky; a load was attempted while full.

Behaviour:
- Reset: the whole design uses one clock (clk) and one reset (reset), which is asynchronous and active-high. While reset=1, every staging slot, output slot, count_out, staged_count and overflow is 0. This holds mid-operation too, with no partial transfer.
- Load only (loadn=0, advancen=1):
  - If not full: slot[staged_count] <= bus and staged_count += 1. Latency 1 edge; the word is visible on staged_count only.
  - If full: bus is dropped, the staging rank is unchanged, and overflow <= 1.
- Advance only (loadn=1, advancen=0):
  - Output slots <= staging slots; count_out <= staged_count.
  - Staging slots <= 0; staged_count <= 0.
  - Advance with staged_count=0 is legal: outputs become all-zero and count_out becomes 0.
- Load and advance together:
  - The output rank takes the pre-edge staging contents, without the current bus word.
  - The staging rank restarts as slot0 <= bus, other slots 0, staged_count <= 1.
  - overflow is not set, even if the rank was full.
- Neither strobe active: all state holds.
- Output rank changes only on an advance edge or on reset. It holds stable across any number of loads, so the decoder sees a stable instruction while the next one is fetched.
- Unused output slots (index >= count_out) always read 0.
- overflow is cleared only by reset.
- Simulation-only check: any edge with loadn=0 and an X/Z bit on bus raises $error("Attempting to load %b", bus).

Decomposition:
- Shared constants header: WIDTH default, OPERANDS default, and the CW derivation function, shared with the control-ROM generator and the bench.
- One sub-module, ir_slot: a WIDTH-bit register with async reset, load enable and synchronous clear. Instantiate it OPERANDS+1 times for staging and OPERANDS+1 times for output.
- Counter, full and overflow logic stay in the top level.

Test Plan:
- Reset mid-fill: load 8'hA5, then assert reset between edges -> staged_count=0 immediately; all outputs 0.
- Three-word instruction (OPERANDS=2): load 8'h3C, 8'h11, 8'h22, then advance -> instr_out=8'h3C, operand_out=16'h2211, count_out=3, staged_count=0.
- Short instruction: load 8'h07, advance -> instr_out=8'h07, operand_out=0, count_out=1.
- Overflow: load 4 words with no advance -> full=1 after the 3rd; the 4th is dropped; overflow=1. Advance -> overflow stays 1 until reset.
- Simultaneous: stage 8'h10, 8'h20, then load 8'h30 with advance on the same edge -> instr_out=8'h10, operand_out[7:0]=8'h20, count_out=2, staged_count=1. The next advance gives instr_out=8'h30.
- Output hold and empty advance: after a loaded instruction, issue 5 loads with no advance -> outputs unchanged. An advance with nothing staged -> all outputs 0, count_out=0.
- Parameter sweep: rerun the tests above with OPERANDS=0 and WIDTH=16 -> operand_out is absent/zero-width, and full is set after 1 load.
